// File: rtl/prog_clk_divider.sv
// Runtime-programmable integer clock divider: clk_out = clk/N with a tick per rising edge.
// Define PROG_CLK_DIVIDER_ODD_DUTY50_EN to stretch odd-N high time to an exact 50% duty.
module prog_clk_divider #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             busy,
    output logic             div_err,
    output logic [WIDTH-1:0] div_active,
    output logic             clk_out,
    output logic             tick
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] div_active_q, div_active_d;
    logic             out_q, out_d;
    logic             tick_q, tick_d;
    logic             busy_q, busy_d;
    logic             div_err_q, div_err_d;

    logic load_ok, last, apply;

    always_comb begin
        load_ok = div_load && (div_in >= WIDTH'(2));
        last    = (cnt_q == div_active_q - WIDTH'(1));
        // Pending divisor lands at a period boundary, or at once while stopped.
        apply   = busy_q && (!en || last);

        cnt_d        = '0;
        out_d        = 1'b0;
        tick_d       = 1'b0;
        if (en) begin
            cnt_d  = last ? '0 : cnt_q + WIDTH'(1);
            out_d  = (cnt_q < (div_active_q >> 1));
            tick_d = (cnt_q == '0);
        end

        div_active_d = apply ? pend_q : div_active_q;
        pend_d       = load_ok ? div_in : pend_q;
        busy_d       = load_ok ? 1'b1 : (apply ? 1'b0 : busy_q);
        div_err_d    = div_load && !load_ok;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            pend_q       <= '0;
            div_active_q <= WIDTH'(DEFAULT_DIV);
            out_q        <= 1'b0;
            tick_q       <= 1'b0;
            busy_q       <= 1'b0;
            div_err_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            div_active_q <= div_active_d;
            out_q        <= out_d;
            tick_q       <= tick_d;
            busy_q       <= busy_d;
            div_err_q    <= div_err_d;
        end
    end

`ifdef PROG_CLK_DIVIDER_ODD_DUTY50_EN
    logic out_neg_q, out_neg_d;

    always_comb out_neg_d = out_q;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) out_neg_q <= 1'b0;
        else     out_neg_q <= out_neg_d;
    end

    // Half-cycle extension only for odd N; out_q is low at every boundary, so N swaps are clean.
    assign clk_out = out_q | (out_neg_q & div_active_q[0]);
`else
    assign clk_out = out_q;
`endif

    assign busy       = busy_q;
    assign div_err    = div_err_q;
    assign div_active = div_active_q;
    assign tick       = tick_q;

endmodule

// File: tb/tb_prog_clk_divider.sv
// Bench for prog_clk_divider: period-phase reference model checked every cycle,
// directed scenarios with hand-computed expectations, then randomized traffic.
module tb_prog_clk_divider;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [W-1:0] div_in;
    logic         div_load;
    logic         busy, div_err, clk_out, tick;
    logic [W-1:0] div_active;

    int n_pass  = 0;
    int n_total = 0;

    prog_clk_divider #(.WIDTH(W), .DEFAULT_DIV(4)) dut (
        .clk(clk), .rst(rst), .en(en), .div_in(div_in), .div_load(div_load),
        .busy(busy), .div_err(div_err), .div_active(div_active),
        .clk_out(clk_out), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: position within the current output period, period length, pending divisor.
    int m_ph, m_n, m_pend;
    bit m_pv, m_out, m_prev, m_tick, m_err;

    task automatic model_reset();
        m_ph = 0; m_n = 4; m_pend = 0; m_pv = 0;
        m_out = 0; m_prev = 0; m_tick = 0; m_err = 0;
    endtask

    task automatic model_step();
        int din;
        din    = int'(div_in);
        m_prev = m_out;
        if (en) begin
            m_out  = (m_ph < m_n / 2);
            m_tick = (m_ph == 0);
            if (m_ph == m_n - 1) begin
                m_ph = 0;
                if (m_pv) begin m_n = m_pend; m_pv = 0; end
            end else m_ph++;
        end else begin
            m_out = 0; m_tick = 0; m_ph = 0;
            if (m_pv) begin m_n = m_pend; m_pv = 0; end
        end
        m_err = div_load && (din < 2);
        if (div_load && din >= 2) begin m_pend = din; m_pv = 1; end
    endtask

    initial begin
        bit exp_clk;
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
            #1;
`ifdef PROG_CLK_DIVIDER_ODD_DUTY50_EN
            exp_clk = m_out | (m_prev & m_n[0]);
`else
            exp_clk = m_out;
`endif
            chk("m_clk_out", int'(clk_out), int'(exp_clk));
            chk("m_tick", int'(tick), int'(m_tick));
            chk("m_busy", int'(busy), int'(m_pv));
            chk("m_div_err", int'(div_err), int'(m_err));
            chk("m_div_active", int'(div_active), m_n);
        end
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_seq [8];
        int hi, tk;
        exp_seq = '{1, 1, 0, 0, 1, 1, 0, 0};
        rst = 1; en = 0; div_in = '0; div_load = 0;
        step(); step();
        chk("rst_div_active", int'(div_active), 4);
        chk("rst_clk_out", int'(clk_out), 0);
        chk("rst_busy", int'(busy), 0);

        // Free-running N=4 after reset release
        rst = 0; en = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("n4_clk_out", int'(clk_out), int'(exp_seq[i]));
            chk("n4_tick", int'(tick), (i % 4 == 0) ? 1 : 0);
        end

        // Load 6 mid-period: current period finishes at 4 cycles
        step(); step();
        div_load = 1; div_in = 8'd6;
        step(); div_load = 0;
        chk("n6_busy_pending", int'(busy), 1);
        chk("n6_active_old", int'(div_active), 4);
        step();
        chk("n6_busy_clear", int'(busy), 0);
        chk("n6_active_new", int'(div_active), 6);
        hi = 0; tk = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (i == 0) chk("n6_first_tick", int'(tick), 1);
            hi += int'(clk_out); tk += int'(tick);
        end
        chk("n6_high_cycles", hi, 6);
        chk("n6_ticks", tk, 2);

        // Load 5
        div_load = 1; div_in = 8'd5;
        step(); div_load = 0;
        for (int i = 0; i < 5; i++) step();
        chk("n5_active", int'(div_active), 5);
        hi = 0;
        for (int i = 0; i < 10; i++) begin step(); hi += int'(clk_out); end
`ifndef PROG_CLK_DIVIDER_ODD_DUTY50_EN
        chk("n5_high_cycles", hi, 4);
`endif

        // Rejected loads
        div_load = 1; div_in = 8'd1;
        step();
        chk("err_div1", int'(div_err), 1);
        div_in = 8'd0;
        step(); div_load = 0;
        chk("err_div0", int'(div_err), 1);
        chk("err_busy", int'(busy), 0);
        step();
        chk("err_clear", int'(div_err), 0);
        chk("err_active", int'(div_active), 5);

        // Stop with N=7 pending
        div_load = 1; div_in = 8'd7;
        step(); div_load = 0;
        chk("n7_busy", int'(busy), 1);
        en = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("n7_stop_active", int'(div_active), 7);
            chk("n7_stop_clk", int'(clk_out), 0);
            chk("n7_stop_tick", int'(tick), 0);
        end
        en = 1;
        step();
        chk("n7_restart_tick", int'(tick), 1);
        chk("n7_restart_clk", int'(clk_out), 1);
        tk = 0;
        for (int i = 0; i < 14; i++) begin step(); tk += int'(tick); end
        chk("n7_ticks", tk, 2);

        // Async reset between edges with a load pending
        div_load = 1; div_in = 8'd9;
        step(); div_load = 0;
        #2 rst = 1;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_active", int'(div_active), 4);
        chk("arst_clk", int'(clk_out), 0);
        chk("arst_tick", int'(tick), 0);
        step(); rst = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("arst_n4_clk", int'(clk_out), int'(exp_seq[i]));
        end
        chk("arst_no_pending", int'(div_active), 4);

        // Randomized traffic; the compare process does the checking
        for (int i = 0; i < 4000; i++) begin
            en       = ($urandom_range(0, 15) != 0);
            div_load = ($urandom_range(0, 9) == 0);
            div_in   = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 255))
                                                   : W'($urandom_range(0, 12));
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1;
                step(); step();
                rst = 0;
            end else step();
        end
        div_load = 0;
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/prog_clk_divider.md
Name: prog_clk_divider

Overview:
- Runtime-programmable integer clock divider, successor to the fixed divide-by-4 block.
- Produces clk_out at f_clk/N with N in [2, 2^WIDTH-1]. Also produces a one-cycle tick strobe aligned to each clk_out rising edge.
- Divisor changes are staged and applied only at a period boundary, so no runt or glitch pulses occur.
- Sits in the clock/timing utilities, feeding slow-domain enables and derived clocks.

Parameters:
- WIDTH, 8, width of the divisor and of the internal counter.
- DEFAULT_DIV, 4, divisor loaded at reset; must be >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  run enable; low stops and re-aligns the divider.
- div_in  in  WIDTH  requested divisor N.
- div_load  in  1  one-cycle strobe; captures div_in.
- busy  out  1  a captured divisor is pending application.
- div_err  out  1  one-cycle pulse; the load was rejected (div_in < 2).
- div_active  out  WIDTH  divisor currently in effect.
- clk_out  out  1  divided output.
- tick  out  1  one-cycle pulse coinciding with a clk_out rising edge.

Behaviour:
- Reset (async, at any time, including mid-period or with a load pending):
  - cnt=0, clk_out=0, tick=0, busy=0, div_err=0, div_active=DEFAULT_DIV.
  - Pending register cleared.
- Running (en=1), each posedge:
  - cnt <= (cnt==N-1) ? 0 : cnt+1.
  - out_r <= (cnt < N/2), with integer floor and cnt taken before increment.
  - tick <= (cnt==0).
  - Period is exactly N cycles; high time is floor(N/2) cycles.
  - After reset/enable, the first enabled edge drives clk_out=1 and tick=1 (latency 1 cycle).
- Divisor load:
  - div_load with div_in >= 2: div_in goes into the pending register and busy=1 on the next cycle.
  - A second load while busy overwrites the pending value; last writer wins.
  - div_load with div_in < 2: ignored, div_err=1 for one cycle, and any existing pending value is kept.
  - Application: on the edge where cnt==N-1 and busy=1, cnt wraps to 0, div_active takes the pending value, and busy goes to 0. The next period uses the new N.
  - A load in the same cycle as the boundary edge is not applied at that boundary; it waits for the next boundary, one full old period later.
- Enable low (en=0), each posedge:
  - cnt<=0, out_r<=0, tick<=0.
  - A pending value is applied immediately (div_active updated, busy=0).
  - A div_load during en=0 is valid for one edge and then applied on the following edge.
  - en 1->0 mid-period truncates the current period with clk_out low. This is the only permitted short pulse.
- Arithmetic: cnt is WIDTH bits, compared against div_active-1. No overflow is possible, since N <= 2^WIDTH-1.
- All outputs are registered. No combinational path from inputs to outputs, except the clk_out OR-path described under the optional feature.

Optional Feature:
- Macro: PROG_CLK_DIVIDER_ODD_DUTY50_EN.
- Defined:
  - A negedge-clk flop copies out_r; clk_out = out_r | out_neg, for odd N only.
  - Odd N gives a high time of (N/2)+0.5 cycles, i.e. 50% duty.
  - Even N is unchanged; out_neg is masked.
  - out_neg resets to 0 asynchronously.
- Undefined: clk_out = out_r; odd N has high time floor(N/2) and low time ceil(N/2). No negedge logic is present.

Test Plan:
- Reset released with en=1 and no loads: clk_out toggles 1,1,0,0 repeating (period 4). tick pulses every 4 cycles, aligned to clk_out rise. div_active=4.
- Load N=6 at mid-period of N=4:
  - busy=1 until the boundary.
  - The current period completes at 4 cycles.
  - The next periods are 6 cycles with high=3; div_active=6 at the boundary; busy then 0.
- Load N=5, macro undefined: high 2 / low 3. Macro defined: high 2.5 / low 2.5, measured between clk_out edges in the simulator.
- Load div_in=1 and div_in=0: div_err pulses one cycle each; div_active, busy and the period are unchanged.
- en=0 for 3 cycles mid-period with N=7 pending:
  - clk_out=0 and tick=0 while en is low.
  - div_active=7 on the first en=0 edge.
  - After en returns to 1, the first edge gives tick=1 and clk_out=1, followed by 7-cycle periods.
- Async rst asserted between clock edges while busy=1: all outputs reach their reset values immediately; pending discarded; after release, behaviour matches the first scenario.
